// File: rtl/render_pkg.sv
// Shared definitions for the render stream generator.
// Holds the field widths, the pixel-beat program code, the command word
// layout and the generator FSM state encoding.
package render_pkg;

    localparam int X_W     = 11;
    localparam int Y_W     = 12;
    localparam int COLOR_W = 32;
    localparam int PROG_W  = 6;

    // program_out value that marks a background pixel beat
    localparam logic [PROG_W-1:0] PROG_PIXEL = 6'd0;

    // One rectangle-programming command as stored in the FIFO
    typedef struct packed {
        logic [PROG_W-1:0]  id;
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [X_W-1:0]     w;
        logic [Y_W-1:0]     h;
        logic [COLOR_W-1:0] color;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SCAN  = 2'd2
    } state_e;

endpackage

// File: rtl/render_cmd_fifo.sv
// Synchronous command FIFO for the render stream generator.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset (flush)
//   push, push_data write one command word (ignored when full)
//   pop, pop_data   read one command word; pop_data shows the head entry
//   empty           no entries stored
//   full_next       FIFO will be full after this cycle's push/pop
// DEPTH must be a power of two (pointers wrap naturally).
module render_cmd_fifo
    import render_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t pop_data,
    output logic empty,
    output logic full_next
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    cmd_t            mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_next_s;
    logic            push_ok_s;
    logic            pop_ok_s;

    assign push_ok_s    = push && (count_r != CW'(DEPTH));
    assign pop_ok_s     = pop && (count_r != CW'(0));
    assign count_next_s = count_r + CW'(push_ok_s) - CW'(pop_ok_s);
    assign empty        = (count_r == CW'(0));
    assign full_next    = (count_next_s == CW'(DEPTH));
    assign pop_data     = mem_r[rd_ptr_r];

    // Pointer and occupancy update; reset flushes by clearing them
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
        end
    end

    // Storage write; contents need no reset since the pointers gate reads
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/render_stream_gen.sv
// Upstream source of the rectangle-renderer stream.
// Buffers shape commands, issues them as program beats between frames and,
// on request, raster-scans the screen emitting one background pixel per cycle.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (cmd_ready = FIFO not full)
//   cmd_id..cmd_color        command fields; cmd_id 0 is accepted and dropped
//   frame_start              request one frame scan
//   frame_busy, frame_done   scan in progress / last pixel beat
//   out_valid, program_out, x_out, y_out, w_out, h_out, color_out  beat bus
// Optional: define RENDER_STREAM_GEN_STATS_EN to add frames_cnt and
// starts_dropped saturating counters.
module render_stream_gen
    import render_pkg::*;
#(
    parameter int               SCREEN_W  = 1080,
    parameter int               SCREEN_H  = 2160,
    parameter logic [31:0]      BG_COLOR  = 32'hFF0000FF,
    parameter int               CMD_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [PROG_W-1:0]  cmd_id,
    input  logic [X_W-1:0]     cmd_x,
    input  logic [Y_W-1:0]     cmd_y,
    input  logic [X_W-1:0]     cmd_w,
    input  logic [Y_W-1:0]     cmd_h,
    input  logic [COLOR_W-1:0] cmd_color,
    input  logic               frame_start,
    output logic               frame_busy,
    output logic               frame_done,
    output logic               out_valid,
    output logic [PROG_W-1:0]  program_out,
    output logic [X_W-1:0]     x_out,
    output logic [Y_W-1:0]     y_out,
    output logic [X_W-1:0]     w_out,
    output logic [Y_W-1:0]     h_out,
    output logic [COLOR_W-1:0] color_out
`ifdef RENDER_STREAM_GEN_STATS_EN
    ,
    output logic [15:0]        frames_cnt,
    output logic [7:0]         starts_dropped
`endif
);

    localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

    state_e             state_r, state_next_s;
    logic               pending_r, pending_next_s;
    logic [X_W-1:0]     x_cnt_r, x_cnt_next_s;
    logic [Y_W-1:0]     y_cnt_r, y_cnt_next_s;
    logic               cmd_ready_r;

    logic               out_valid_r, valid_next_s;
    logic               frame_busy_r, busy_next_s;
    logic               frame_done_r, done_next_s;
    logic [PROG_W-1:0]  prog_r, prog_next_s;
    logic [X_W-1:0]     x_out_r, x_next_s;
    logic [Y_W-1:0]     y_out_r, y_next_s;
    logic [X_W-1:0]     w_out_r, w_next_s;
    logic [Y_W-1:0]     h_out_r, h_next_s;
    logic [COLOR_W-1:0] color_r, color_next_s;

    logic               push_s;
    logic               pop_s;
    logic               emit_prog_s;
    logic               emit_pix_s;
    logic               fifo_empty_s;
    logic               fifo_full_next_s;
    cmd_t               cmd_in_s;
    cmd_t               fifo_head_s;

    // cmd_id 0 completes the handshake but is never stored
    assign push_s   = cmd_valid && cmd_ready_r && (cmd_id != PROG_PIXEL);
    assign cmd_in_s = '{id: cmd_id, x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, color: cmd_color};

    render_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (cmd_in_s),
        .pop       (pop_s),
        .pop_data  (fifo_head_s),
        .empty     (fifo_empty_s),
        .full_next (fifo_full_next_s)
    );

    // Next-state and next-beat selection
    always_comb begin
        state_next_s   = state_r;
        pending_next_s = pending_r;
        x_cnt_next_s   = x_cnt_r;
        y_cnt_next_s   = y_cnt_r;
        pop_s          = 1'b0;
        emit_prog_s    = 1'b0;
        emit_pix_s     = 1'b0;

        case (state_r)
            ST_IDLE, ST_DRAIN: begin
                if (frame_start) begin
                    pending_next_s = 1'b1;
                end else begin
                    pending_next_s = pending_r;
                end
                // IDLE pops immediately so an accepted command appears two cycles later
                if (!fifo_empty_s) begin
                    pop_s        = 1'b1;
                    emit_prog_s  = 1'b1;
                    state_next_s = ST_DRAIN;
                end else if (state_r == ST_DRAIN) begin
                    state_next_s = ST_IDLE;
                end else if (frame_start || pending_r) begin
                    state_next_s   = ST_SCAN;
                    pending_next_s = 1'b0;
                    x_cnt_next_s   = X_W'(0);
                    y_cnt_next_s   = Y_W'(0);
                    emit_pix_s     = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                // x_cnt_r/y_cnt_r hold the coordinate currently on the bus
                if ((x_cnt_r == X_LAST) && (y_cnt_r == Y_LAST)) begin
                    state_next_s = ST_IDLE;
                end else if (x_cnt_r == X_LAST) begin
                    x_cnt_next_s = X_W'(0);
                    y_cnt_next_s = y_cnt_r + Y_W'(1);
                    emit_pix_s   = 1'b1;
                end else begin
                    x_cnt_next_s = x_cnt_r + X_W'(1);
                    emit_pix_s   = 1'b1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output bus contents for the next cycle; fields hold when no beat
    always_comb begin
        valid_next_s = 1'b0;
        busy_next_s  = 1'b0;
        done_next_s  = 1'b0;
        prog_next_s  = prog_r;
        x_next_s     = x_out_r;
        y_next_s     = y_out_r;
        w_next_s     = w_out_r;
        h_next_s     = h_out_r;
        color_next_s = color_r;
        if (emit_prog_s) begin
            valid_next_s = 1'b1;
            prog_next_s  = fifo_head_s.id;
            x_next_s     = fifo_head_s.x;
            y_next_s     = fifo_head_s.y;
            w_next_s     = fifo_head_s.w;
            h_next_s     = fifo_head_s.h;
            color_next_s = fifo_head_s.color;
        end else if (emit_pix_s) begin
            valid_next_s = 1'b1;
            busy_next_s  = 1'b1;
            done_next_s  = (x_cnt_next_s == X_LAST) && (y_cnt_next_s == Y_LAST);
            prog_next_s  = PROG_PIXEL;
            x_next_s     = x_cnt_next_s;
            y_next_s     = y_cnt_next_s;
            w_next_s     = X_W'(0);
            h_next_s     = Y_W'(0);
            color_next_s = BG_COLOR;
        end else begin
            valid_next_s = 1'b0;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            pending_r    <= 1'b0;
            x_cnt_r      <= X_W'(0);
            y_cnt_r      <= Y_W'(0);
            cmd_ready_r  <= 1'b0;
            out_valid_r  <= 1'b0;
            frame_busy_r <= 1'b0;
            frame_done_r <= 1'b0;
            prog_r       <= PROG_W'(0);
            x_out_r      <= X_W'(0);
            y_out_r      <= Y_W'(0);
            w_out_r      <= X_W'(0);
            h_out_r      <= Y_W'(0);
            color_r      <= COLOR_W'(0);
        end else begin
            state_r      <= state_next_s;
            pending_r    <= pending_next_s;
            x_cnt_r      <= x_cnt_next_s;
            y_cnt_r      <= y_cnt_next_s;
            cmd_ready_r  <= !fifo_full_next_s;
            out_valid_r  <= valid_next_s;
            frame_busy_r <= busy_next_s;
            frame_done_r <= done_next_s;
            prog_r       <= prog_next_s;
            x_out_r      <= x_next_s;
            y_out_r      <= y_next_s;
            w_out_r      <= w_next_s;
            h_out_r      <= h_next_s;
            color_r      <= color_next_s;
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign out_valid   = out_valid_r;
    assign frame_busy  = frame_busy_r;
    assign frame_done  = frame_done_r;
    assign program_out = prog_r;
    assign x_out       = x_out_r;
    assign y_out       = y_out_r;
    assign w_out       = w_out_r;
    assign h_out       = h_out_r;
    assign color_out   = color_r;

`ifdef RENDER_STREAM_GEN_STATS_EN
    logic [15:0] frames_cnt_r;
    logic [7:0]  starts_dropped_r;

    // Saturating frame and dropped-start counters
    always_ff @(posedge clk) begin
        if (rst) begin
            frames_cnt_r     <= 16'd0;
            starts_dropped_r <= 8'd0;
        end else begin
            if (frame_done_r && (frames_cnt_r != 16'hFFFF)) begin
                frames_cnt_r <= frames_cnt_r + 16'd1;
            end
            if ((state_r == ST_SCAN) && frame_start && (starts_dropped_r != 8'hFF)) begin
                starts_dropped_r <= starts_dropped_r + 8'd1;
            end
        end
    end

    assign frames_cnt     = frames_cnt_r;
    assign starts_dropped = starts_dropped_r;
`endif

endmodule

// File: doc/render_stream_gen.md
Name: render_stream_gen

Overview:
- Upstream source for the rectangle-renderer pipeline; it drives the stream that the renderer chain consumes.
- Accepts shape-programming commands through a valid/ready port and buffers them in a small FIFO.
- Between frames it issues buffered commands as program beats. On request it raster-scans the screen, emitting one background pixel beat per cycle.
- Renderer stages downstream overlay their rectangles on these beats.

Parameters:
- SCREEN_W, 1080, pixels per line (x range 0..SCREEN_W-1)
- SCREEN_H, 2160, lines per frame (y range 0..SCREEN_H-1)
- BG_COLOR, 32'hFF0000FF, ARGB background colour on pixel beats
- CMD_DEPTH, 4, command FIFO depth (power of two, >=2)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full; a command transfers when cmd_valid && cmd_ready
- cmd_id  in  6  target renderer ID, 1..63; 0 is illegal
- cmd_x  in  11  rect origin x
- cmd_y  in  12  rect origin y
- cmd_w  in  11  rect width
- cmd_h  in  12  rect height
- cmd_color  in  32  rect ARGB colour
- frame_start  in  1  single-cycle request to scan one frame
- frame_busy  out  1  high while scanning
- frame_done  out  1  one-cycle pulse coincident with the last pixel beat
- out_valid  out  1  beat present on the output bus
- program_out  out  6  0 = pixel beat; N = program renderer N
- x_out  out  11  pixel x, or rect x on a program beat
- y_out  out  12  pixel y, or rect y on a program beat
- w_out  out  11  rect width on a program beat, 0 on a pixel beat
- h_out  out  12  rect height on a program beat, 0 on a pixel beat
- color_out  out  32  BG_COLOR on a pixel beat, rect colour on a program beat

Behaviour:
- All outputs are registered.
- Reset: every output 0, including cmd_ready, which stays 0 while rst is high. The FIFO is flushed, the pending-start flag is cleared, and the scan counters are zeroed. cmd_ready = !full from the first cycle after rst falls.
- Reset mid-scan or mid-drain aborts: outputs return to reset values the next cycle and no frame_done is produced.
- FIFO:
  - Push on handshake; push and pop in the same cycle are legal.
  - Commands with cmd_id==0 are accepted and discarded (never pushed).
  - Field values are not range-checked.
- FSM states are IDLE, DRAIN and SCAN.
- IDLE:
  - FIFO non-empty -> DRAIN.
  - FIFO empty and (frame_start or pending) -> SCAN, clear pending.
  - frame_start while FIFO non-empty sets pending.
- DRAIN:
  - Pop one command per cycle and emit it as a program beat the next cycle (out_valid=1, program_out=cmd_id, fields copied).
  - When the FIFO is empty, return to IDLE.
  - frame_start sets pending.
  - Commands pushed during DRAIN are drained in the same pass.
- SCAN:
  - Emit SCREEN_W*SCREEN_H consecutive pixel beats in raster order: x increments fastest, wraps to 0 at SCREEN_W-1, then y increments.
  - Pixel beats carry program_out=0, w_out=h_out=0, color_out=BG_COLOR.
  - The first beat (0,0) appears in the cycle after SCAN is entered.
  - frame_busy is high exactly during the pixel beats.
  - The beat (SCREEN_W-1, SCREEN_H-1) carries frame_done=1, then the FSM returns to IDLE.
  - frame_start during SCAN is dropped.
  - Commands are accepted into the FIFO during SCAN but issued only after frame_done.
- Latency:
  - Command accepted in cycle N with an empty FIFO in IDLE -> program beat in cycle N+2.
  - frame_start in cycle N in IDLE with an empty FIFO -> pixel (0,0) in cycle N+1.
- Any cycle with no beat: out_valid=0; other output fields hold their last value.

Optional Feature:
- Macro: RENDER_STREAM_GEN_STATS_EN.
- When defined, add two outputs:
  - frames_cnt (16 bits): increments on frame_done, saturates at 16'hFFFF.
  - starts_dropped (8 bits): increments on each frame_start ignored in SCAN, saturates at 8'hFF.
- Both counters are cleared by rst.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package render_pkg holds:
  - widths X_W=11, Y_W=12, COLOR_W=32, PROG_W=6;
  - constant PROG_PIXEL=0;
  - command struct/typedef (id, x, y, w, h, color);
  - FSM state enum.
- Sub-module render_cmd_fifo: a synchronous FIFO of command words with full/empty flags, parameterised by depth.

Test Plan:
- Reset: hold rst 2 cycles -> all outputs 0 and cmd_ready=0; cycle after release -> cmd_ready=1, out_valid=0.
- Program beat: push id=1, x=0, y=0, w=1080, h=2160, color=FF000000 -> exactly one beat 2 cycles later with identical fields and program_out=1. Push id=0 -> no beat.
- Scan (SCREEN_W=8, SCREEN_H=4):
  - Pulse frame_start -> 32 consecutive beats (0,0),(1,0)..(7,0),(0,1)..(7,3), all color FF0000FF and program_out=0.
  - frame_busy is high for exactly those 32 cycles.
  - frame_done only with (7,3).
- Drain before scan: push 3 commands, with frame_start in the same cycle as the last push -> 3 program beats in push order, then pixel (0,0) on the immediately following beat.
- Backpressure: during a scan, offer 5 commands with CMD_DEPTH=4 -> 4 accepted, then cmd_ready=0 until the drain begins after frame_done; a frame_start mid-scan is dropped (starts_dropped=1 when STATS_EN).
- Abort: assert rst at pixel beat 10 -> next cycle out_valid=0 and frame_busy=0, FIFO empty, no frame_done ever pulses.
